// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer that owns the HI/LO pair.
// 32-cycle shift-add multiply or restoring divide, one sign-fix cycle, then commit.
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mf_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [63:0] r_prod;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic [31:0] r_opa;
  logic        r_sa;
  logic        r_sb;
  logic        r_is_div;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Operand magnitudes; 0x80000000 negates to itself and is treated as unsigned.
  assign w_signed = ~op[0];
  assign w_sa     = w_signed & op_a[31];
  assign w_sb     = w_signed & op_b[31];
  assign w_mag_a  = w_sa ? (32'd0 - op_a) : op_a;
  assign w_mag_b  = w_sb ? (32'd0 - op_b) : op_b;

  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
  assign w_diff   = w_rem_sh[31:0] - r_divisor;

  assign w_prod_fix = (r_sa ^ r_sb) ? (64'd0 - r_prod) : r_prod;
  assign w_quo_fix  = (r_sa ^ r_sb) ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix  = r_sa ? (32'd0 - r_rem) : r_rem;

  assign busy  = (r_state != S_IDLE);
  assign stall = busy & (start | mf_req);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Sequencer FSM, datapath iteration and HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= 5'd0;
      r_prod    <= 64'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_opa     <= 32'd0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_is_div  <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_state   <= S_RUN;
                r_count   <= 5'd0;
                r_sa      <= w_sa;
                r_sb      <= w_sb;
                r_is_div  <= op[1];
                r_dz      <= op[1] & (op_b == 32'd0);
                r_opa     <= op_a;
                r_prod    <= 64'd0;
                r_mcand   <= {32'd0, w_mag_a};
                r_mplier  <= w_mag_b;
                r_rem     <= 32'd0;
                r_quo     <= w_mag_a;
                r_divisor <= w_mag_b;
              end
              3'd4:    r_hi <= op_a;
              3'd5:    r_lo <= op_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_count <= r_count + 5'd1;
          if (r_is_div) begin
            r_rem <= w_ge ? w_diff : w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], w_ge};
          end else begin
            r_prod   <= r_mplier[0] ? (r_prod + r_mcand) : r_prod;
            r_mcand  <= {r_mcand[62:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
          end
          if (r_count == 5'(ITER - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end else if (r_dz) begin
            r_hi <= r_opa;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, arithmetic, stall and reset.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mf_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  muldiv_sequencer #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mf_req(mf_req), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a command at the next edge, then count cycles until done (bounded).
  task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk);
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 3'd6; op_a = 32'd0; op_b = 32'd0; mf_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state busy=%0b done=%0b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult();
    int lat, bc;
    issue_and_wait(3'd0, 32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d expected 33", lat); end
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d expected 33", bc); end
    checks++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
      errors++; $display("FAIL mult_signed hi=%h lo=%h expected ffffffff fffffff1", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width done=%0b expected 0", done); end
  endtask

  task automatic test_multu();
    int lat, bc;
    issue_and_wait(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if ({hi, lo} !== {32'hFFFF_FFFE, 32'h0000_0001} || lat !== 33) begin
      errors++; $display("FAIL multu_max hi=%h lo=%h lat=%0d expected fffffffe 00000001 33", hi, lo, lat);
    end
  endtask

  task automatic test_div();
    int lat, bc;
    issue_and_wait(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_neg7_by_2 hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
    end
    issue_and_wait(3'd2, 32'd7, 32'hFFFF_FFFE, lat, bc);
    checks++;
    if ({hi, lo} !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_7_by_neg2 hi=%h lo=%h expected 00000001 fffffffd", hi, lo);
    end
    issue_and_wait(3'd3, 32'd7, 32'd2, lat, bc);
    checks++;
    if ({hi, lo} !== {32'd1, 32'd3}) begin
      errors++; $display("FAIL divu_7_by_2 hi=%h lo=%h expected 00000001 00000003", hi, lo);
    end
    issue_and_wait(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin
      errors++; $display("FAIL div_min_by_neg1 hi=%h lo=%h expected 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    issue_and_wait(3'd3, 32'd100, 32'd0, lat, bc);
    checks++;
    if ({hi, lo} !== {32'h0000_0064, 32'hFFFF_FFFF} || lat !== 33) begin
      errors++; $display("FAIL divu_by_zero hi=%h lo=%h lat=%0d expected 00000064 ffffffff 33", hi, lo, lat);
    end
    issue_and_wait(3'd2, 32'hFFFF_FFF0, 32'd0, lat, bc);
    checks++;
    if ({hi, lo} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL div_neg_by_zero hi=%h lo=%h expected fffffff0 ffffffff", hi, lo);
    end
  endtask

  task automatic test_mthi_stall();
    int lat;
    // MTHI with mf_req in the same idle cycle must not stall.
    @(negedge clk);
    start = 1'b1; op = 3'd4; op_a = 32'h1234_5678; mf_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL idle_no_stall stall=%0b expected 0", stall); end
    @(negedge clk);
    start = 1'b0; mf_req = 1'b0;
    checks++;
    if ({hi, lo, done, busy} !== {32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mthi hi=%h lo=%h done=%0b busy=%0b expected 12345678 ffffffff 0 0", hi, lo, done, busy);
    end
    @(negedge clk);
    start = 1'b1; op = 3'd0; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    mf_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mf_stall stall=%0b expected 1", stall); end
    start = 1'b1; op = 3'd1; op_a = 32'd2; op_b = 32'd2;
    repeat (5) @(negedge clk);
    checks++;
    if ({stall, hi} !== {1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL busy_hold stall=%0b hi=%h expected 1 12345678", stall, hi);
    end
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (done) begin lat = k; break; end
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL stall_until_done stall=%0b expected 1", stall); break; end
      @(negedge clk);
    end
    checks++;
    if (lat < 0 || {hi, lo} !== {32'd0, 32'd42}) begin
      errors++; $display("FAIL mult_after_ignored_start hi=%h lo=%h lat=%0d expected 0 42", hi, lo, lat);
    end
    mf_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, lo} !== {1'b0, 32'd42}) begin
      errors++; $display("FAIL second_start_ignored busy=%0b lo=%h expected 0 0000002a", busy, lo);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; op = 3'd2; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL async_reset busy=%0b done=%0b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%0b expected 0", busy); end
    issue_and_wait(3'd1, 32'd3, 32'd4, lat, bc);
    checks++;
    if ({hi, lo} !== {32'd0, 32'd12} || lat !== 33) begin
      errors++; $display("FAIL multu_after_reset hi=%h lo=%h lat=%0d expected 0 0000000c 33", hi, lo, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_mthi_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide controller owning the HI/LO register pair beside the single-cycle ALU in the harvard datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from control and runs a 32-iteration shift-add multiply or restoring divide. It then sign-corrects the result and commits it to HI/LO. It raises stall so the pipeline holds any HI/LO access or new muldiv command issued while an operation is in flight.

Parameters:
ITER, 32, iterations per multiply/divide. Fixed at 32; other values are unsupported.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  command valid; sampled at rising edge
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
op_a  input  32  rs operand (read_data_0)
op_b  input  32  rt operand (read_data_1)
mf_req  input  1  current instruction reads HI or LO (MFHI/MFLO)
busy  output  1  high whenever state != IDLE
stall  output  1  busy & (start | mf_req); combinational
done  output  1  one-cycle pulse when a mul/div result commits
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0, done=0; busy=0; iteration counter=0. Any in-flight operation is discarded and HI/LO are cleared.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in 0..3: latch operand magnitudes, the sign flags sa=op_a[31] and sb=op_b[31], and the signed flag. Set count=0 and go to RUN.
  - Unsigned ops use raw operands and clear the sign flags.
  - 0x80000000 has magnitude 0x80000000, handled as unsigned 32-bit.
- IDLE, start=1, op=4: hi<=op_a at that edge. op=5: lo<=op_a. State stays IDLE; no done, no busy.
- IDLE, op 6/7: ignored.
- RUN: one iteration per edge, count++. At the edge where count==31, go to FIX. RUN lasts exactly 32 cycles.
- Multiply: 64-bit shift-add over the 32 bits of the op_b magnitude.
- Divide: restoring, 1 quotient bit per iteration, 33-bit partial remainder.
- FIX, single edge:
  - Signed multiply: negate the 64-bit product if sa^sb.
  - Signed divide: negate the quotient if sa^sb; negate the remainder if sa.
  - Commit {hi,lo}=product, or hi=remainder, lo=quotient.
  - Go to IDLE and set done=1 for exactly the following cycle.
- Latency: start sampled at edge E0; hi/lo updated and done high after edge E0+33; busy high from after E0 through E0+33.
- Divide by zero (op_b==0, DIV or DIVU): still takes full latency. Result is hi=op_a (unmodified), lo=0xFFFFFFFF. Sign correction is suppressed.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no exception).
- start while busy: ignored; stall=1, so control re-presents the command after done.
- mf_req while busy: stall=1. hi/lo hold their previous values until commit. A read in the done cycle sees the new values.
- start and mf_req together in IDLE: stall=0; the read sees the pre-command hi/lo.
- hi/lo change only at an MTHI/MTLO edge, at the FIX edge, or on reset.

Test Plan:
- Reset, then MULT op_a=0xFFFFFFFD (-3), op_b=5 -> done 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
- DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF, normal latency.
- MTHI 0x12345678 while idle -> hi updates next edge, lo unchanged, done=0. Then start MULT and assert mf_req mid-run -> stall=1 until done. A second start mid-run is ignored, and hi/lo reflect only the first result.
- Start DIV, assert reset=0 at iteration 10 -> busy, done, hi, lo all 0 immediately (asynchronously). After release, state is IDLE and a new MULTU 3x4 gives lo=12, hi=0.
